// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch state, entry type and instruction size
package fetch_ctrl_pkg;
  localparam int RV_INST_BYTES = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: PC unit, instruction memory and decode-side signals of the fetch controller
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_stall;
  logic              redirect_valid;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              dec_ready;
  logic [CNT_W-1:0]  drop_cnt;
  modport master (
    input  pc_in, redirect_valid, imem_ack, imem_rdata, dec_ready,
    output pc_stall, imem_req, imem_addr, inst_valid, inst_data, inst_pc, drop_cnt
  );
  modport slave (
    output pc_in, redirect_valid, imem_ack, imem_rdata, dec_ready,
    input  pc_stall, imem_req, imem_addr, inst_valid, inst_data, inst_pc, drop_cnt
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, simultaneous push/pop and registered head
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [CW-1:0]    count,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign valid = count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-outstanding-read fetch sequencer with stale-response drop and decode FIFO
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t state;
  logic [CW-1:0] count;
  logic pop, push, room, drop;
  logic [ADDR_W+DATA_W-1:0] head;
  assign pop = bus.dec_ready & bus.inst_valid;
  assign room = count < CW'(BUF_DEPTH) | pop;
  assign push = state == WAIT & bus.imem_ack & !bus.redirect_valid;
  assign drop = bus.imem_ack & (state == DRAIN | (state == WAIT & bus.redirect_valid));
  // The PC unit stalls unless it must branch or a wanted fetch lands this cycle
  assign bus.pc_stall = !(bus.redirect_valid | (state == WAIT & bus.imem_ack));
  assign {bus.inst_pc, bus.inst_data} = head;
  fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(bus.redirect_valid),
    .push(push),
    .pop(pop),
    .push_data({bus.imem_addr, bus.imem_rdata}),
    .count(count),
    .valid(bus.inst_valid),
    .head(head)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.imem_req <= 1'b0;
      bus.imem_addr <= '0;
      bus.drop_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (room && !bus.redirect_valid) begin
            bus.imem_addr <= bus.pc_in;
            bus.imem_req <= 1'b1;
            state <= WAIT;
          end
        WAIT:
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            state <= IDLE;
          end else if (bus.redirect_valid) state <= DRAIN;
        DRAIN:
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
      if (drop && !(&bus.drop_cnt)) bus.drop_cnt <= bus.drop_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random fetch traffic checked against a transaction-level model
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int MAX_DROPS = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) bus ();
  fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  bit m_req, m_want;
  logic [31:0] m_addr, pc;
  int m_drops;
  fetch_entry_t q[$];
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h13;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit rs, input bit rd, input bit ak, input bit dr, input logic [31:0] tgt);
    bit pop, push, drop, stall, room;
    logic [31:0] pc_old;
    check("imem_req", bus.imem_req, m_req);
    check("imem_addr", bus.imem_addr, m_addr);
    check("inst_valid", bus.inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("inst_pc", bus.inst_pc, q[0].pc);
      check("inst_data", bus.inst_data, q[0].inst);
    end
    check("drop_cnt", bus.drop_cnt, m_drops);
    reset = rs;
    bus.redirect_valid = rd;
    bus.imem_ack = ak;
    bus.dec_ready = dr;
    bus.pc_in = pc;
    bus.imem_rdata = inst_of(m_addr);
    #1;
    stall = !(rd || (m_req && m_want && ak));
    check("pc_stall", bus.pc_stall, stall);
    pc_old = pc;
    if (rs) begin
      m_req = 0;
      m_want = 0;
      m_addr = 0;
      m_drops = 0;
      q.delete();
      pc = 32'h100;
    end else begin
      pop = dr && q.size() != 0;
      room = q.size() < DEPTH || pop;
      push = m_req && m_want && ak && !rd;
      drop = m_req && ak && (!m_want || rd);
      if (rd) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{pc: m_addr, inst: inst_of(m_addr)});
      end
      if (drop && m_drops < MAX_DROPS) m_drops++;
      if (!m_req) begin
        if (room && !rd) begin
          m_req = 1;
          m_want = 1;
          m_addr = pc_old;
        end
      end else if (ak) m_req = 0;
      else if (rd) m_want = 0;
      if (rd) pc = tgt;
      else if (!stall) pc = pc + RV_INST_BYTES;
    end
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    bus.pc_in = '0;
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.dec_ready = 1'b0;
    m_req = 0;
    m_want = 0;
    m_addr = 0;
    m_drops = 0;
    pc = 0;
    repeat (2) @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    pc = 0;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    check("first_pc", bus.inst_pc, 32'h0);
    check("first_data", bus.inst_data, 32'h13);
    repeat (8) cycle(0, 0, m_req, 0, 0);
    check("full_stall", bus.pc_stall, 1'b1);
    repeat (6) cycle(0, 0, m_req, 1, 0);
    cycle(0, 0, 1, 1, 0);
    if (m_req) cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 32'h40);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    check("drain_drop", bus.drop_cnt, 8'd1);
    cycle(0, 0, 0, 1, 0);
    check("redir_addr", bus.imem_addr, 32'h40);
    cycle(0, 1, 1, 0, 32'h80);
    check("wait_drop", bus.drop_cnt, 8'd2);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    check("post_rst_addr", bus.imem_addr, 32'h100);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)) << 2);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 600; i++) cycle(0, m_req, m_req, 1, 32'($urandom_range(0, 255)) << 2);
    check("drop_sat", bus.drop_cnt, 8'hFF);
    repeat (4) cycle(0, m_req, m_req, 1, 32'h200);
    check("drop_hold", bus.drop_cnt, 8'hFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch between the PC register unit and a handshaked instruction memory.
- Issues one outstanding read per PC value and holds the PC unit via pc_stall until the read completes.
- Drops stale responses after a branch or jump redirect.
- Buffers fetched instructions in a small FIFO toward decode.

Parameters:
ADDR_W, 32, PC/instruction address width
DATA_W, 32, instruction width
BUF_DEPTH, 2, instruction FIFO entries (power of two, >=2)
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
pc_in  in  ADDR_W  current PC from PC unit
pc_stall  out  1  hold PC unit (drives its stall input)
redirect_valid  in  1  OR of taken beq/bneq/bge/ble/jump this cycle
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  read address, stable while imem_req=1
imem_ack  in  1  response valid; data on imem_rdata same cycle
imem_rdata  in  DATA_W  instruction word
inst_valid  out  1  FIFO head valid
inst_data  out  DATA_W  FIFO head instruction
inst_pc  out  ADDR_W  FIFO head PC
dec_ready  in  1  decode pops head when inst_valid=1
drop_cnt  out  CNT_W  saturating count of discarded responses

Behaviour:
- State machine with three states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, result wanted.
  - DRAIN: request outstanding, result to be discarded.
- Reset:
  - state=IDLE, imem_req=0, imem_addr=0, FIFO empty, inst_valid=0, drop_cnt=0.
  - pc_stall follows its combinational equation below.
  - Reset mid-request abandons it; an ack arriving after reset while in IDLE is ignored.
- room = (count < BUF_DEPTH) | (dec_ready & inst_valid).
- IDLE transitions:
  - If room and no redirect_valid: register imem_addr<=pc_in, imem_req<=1, go to WAIT.
  - Otherwise stay in IDLE.
  - A redirect in IDLE means the PC changes this edge, so issue waits one cycle.
- WAIT transitions:
  - imem_req=1, imem_addr held.
  - imem_ack & !redirect_valid: push {imem_addr, imem_rdata}, imem_req<=0, go to IDLE.
  - imem_ack & redirect_valid: discard the response, drop_cnt++, go to IDLE.
  - !imem_ack & redirect_valid: go to DRAIN, keep imem_req=1 until ack.
- DRAIN transitions:
  - On imem_ack: discard, drop_cnt++, imem_req<=0, go to IDLE.
  - redirect_valid in DRAIN: stay in DRAIN.
- pc_stall = !(redirect_valid | (state==WAIT & imem_ack)), purely combinational.
  - The PC advances by 4 exactly in the cycle a wanted fetch completes.
  - The PC takes a branch whenever redirect_valid is high, since the PC unit gives stall priority over branch.
- Latency and throughput:
  - From IDLE, imem_req is high the next cycle.
  - Zero-wait-state memory gives one instruction per 2 cycles.
- Push never overflows, because room is checked at issue and count cannot grow while a request is outstanding.
- FIFO:
  - inst_valid = count!=0; head outputs are registered FIFO contents.
  - Push and pop in the same cycle are both honoured.
- redirect_valid flushes the FIFO (count<=0) and takes priority over a simultaneous pop and push.
- drop_cnt saturates at all-ones.
- imem_ack in IDLE is ignored: no push, no count change.

Decomposition:
- Shared package (e.g. rv_pkg) holds:
  - fetch state enum: IDLE/WAIT/DRAIN
  - fetch entry struct: pc + instruction
  - constant RV_INST_BYTES=4
- One natural sub-module: fetch_fifo. Parameterised synchronous FIFO with flush, push/pop, count, and head outputs.

Test Plan:
- Reset release, pc_in=0, ack one cycle after req with rdata=0x00000013 -> cycle1 imem_req=1, addr=0. Ack cycle has pc_stall=0. Next cycle inst_valid=1, inst_pc=0, inst_data=0x00000013.
- dec_ready=0, pc_in stepping 0,4,8 -> two pushes (pc 0, 4), then controller stays IDLE with imem_req=0 and pc_stall=1. Raising dec_ready resumes the fetch at pc 8.
- Request to 0x10 outstanding, redirect_valid pulse (target 0x40), ack 3 cycles later -> state DRAIN, response dropped, drop_cnt=1, FIFO empty. The next request uses addr=0x40.
- redirect_valid and imem_ack in the same cycle in WAIT -> no push, drop_cnt+1, pc_stall=0 that cycle, FIFO flushed.
- reset asserted while in WAIT, then a late ack -> outputs at reset values, ack ignored, the first post-reset request addresses pc_in.
- Force drop_cnt to 0xFFFF via repeated redirects -> it stays at 0xFFFF.
